router_muxn_rr: RTL
===================

ROUTER_MUXN_RR -- requirements
Module: router_muxn_rr

Interface
REQ-001 The block SHALL have parameter NPORTS, default 4, number of input ports (2..16).
REQ-002 The block SHALL have parameter PORTNO, default 1, destination ID this output port serves.
REQ-003 The block SHALL have parameter DW, default 64, data width.
REQ-004 The block SHALL have parameter DESTW, default 8, destination field width.
REQ-005 The block SHALL have CLK  input  1  clock, all logic on rising edge.
REQ-006 The block SHALL have RST  input  1  reset, synchronous, active-high.
REQ-007 The block SHALL have D  input  [NPORTS][DW]  per-port data.
REQ-008 The block SHALL have DEST  input  [NPORTS][DESTW]  per-port destination ID.
REQ-009 The block SHALL have DEST_VALID  input  [NPORTS]  destination valid, held for the whole packet.
REQ-010 The block SHALL have D_HDR_VALID, D_PLD_VALID  input  [NPORTS] each  header-beat and payload-beat valid.
REQ-011 The block SHALL have D_SOF, D_EOF  input  [NPORTS] each  start-of-frame and end-of-frame markers.
REQ-012 The block SHALL have Q_BP  input  1  downstream backpressure.
REQ-013 The block SHALL have D_BP  output  [NPORTS]  per-port backpressure to the sources.
REQ-014 The block SHALL have Q  output  DW, and Q_HDR_VALID, Q_PLD_VALID, Q_SOF, Q_EOF  output  1 each, all registered.
REQ-015 The block SHALL have GRANT  output  [NPORTS]  one-hot registered owner of the output; all zero when idle.
REQ-016 The block SHALL have COLLISION  output  1  registered one-cycle pulse on contended arbitration.

Function
REQ-017 Port i SHALL request when DEST_VALID[i]=1 and DEST[i]==PORTNO.
REQ-018 The FSM SHALL have two states: IDLE (no owner) and LOCK (one owner g).
REQ-019 In IDLE with at least one request and Q_BP=0, the block SHALL pick the winner combinationally by round-robin, searching from ptr+1 upward with wrap at NPORTS-1 to 0, enter LOCK, set GRANT to the winner and set ptr to the winner index.
REQ-020 In IDLE with Q_BP=1, the block SHALL NOT arbitrate, SHALL assert D_BP for all requesters, and SHALL hold ptr.
REQ-021 In IDLE with no request, the block SHALL drive all output valid/SOF/EOF flags to 0 and hold Q.
REQ-022 Forwarding latency SHALL be exactly one cycle: each accepted input cycle of the owner (the arbitration cycle included) SHALL appear on Q/flags on the next edge.
REQ-023 Accepted cycles are those where the port is owner (or winner in the arbitration cycle) and Q_BP=0.
REQ-024 On an accepted cycle, output flags SHALL equal the owner's D_SOF/D_HDR_VALID/D_PLD_VALID/D_EOF, and Q SHALL equal D[owner].
REQ-025 When Q_BP=1, Q and all output flags SHALL hold their previous values, and D_BP[owner] SHALL be 1.
REQ-026 D_BP[i] SHALL be 1 combinationally for every requesting non-owner i, and 0 for non-requesters.
REQ-027 LOCK SHALL return to IDLE after an accepted cycle with D_EOF[g]=1; in that cycle GRANT clears at the edge, and a new arbitration SHALL take effect no earlier than the next cycle.
REQ-028 If DEST_VALID[g] drops while in LOCK (abort), the FSM SHALL return to IDLE at the next edge, output flags SHALL go to 0, and no Q_EOF SHALL be synthesised.
REQ-029 COLLISION SHALL pulse for one cycle, registered, when arbitration occurs with two or more simultaneous requests.
REQ-030 A requester losing arbitration SHALL be served before the previous winner wins again (starvation-free).

Reset
REQ-031 While RST=1, the block SHALL force state IDLE; ptr=NPORTS-1 (so port 0 wins first); Q=0; all flags, GRANT and COLLISION=0; D_BP=0.
REQ-032 Reset asserted mid-packet SHALL abandon the packet with no Q_EOF, and the first post-reset cycle SHALL behave as IDLE.

Verification
REQ-033 The bench SHALL cover: ports 0 and 1 request PORTNO=1 together with SOF, 1 header, 10 payload beats, EOF -> port 0 granted, COLLISION pulses once, D_BP[1]=1 throughout, Q replays port 0 beats one cycle late, then port 1 granted the cycle after EOF.
REQ-034 The bench SHALL cover: all 4 ports requesting continuously with 1-beat SOF+EOF packets -> GRANT sequence 0,1,2,3,0 with ptr wrapping.
REQ-035 The bench SHALL cover: Q_BP=1 for 3 cycles mid-payload -> Q holds value 5 for 3 extra cycles, D_BP[owner]=1, and no beat is lost or duplicated.
REQ-036 The bench SHALL cover: a port with DEST=2 and DEST_VALID=1 -> never granted, D_BP stays 0, and output flags stay 0.
REQ-037 The bench SHALL cover: DEST_VALID[g] dropped after beat 4 -> IDLE next cycle, no Q_EOF, and the other requester is granted afterwards.
REQ-038 The bench SHALL cover: RST pulsed mid-packet -> all outputs 0, then port 0 wins the first post-reset contention.

Source files
------------

// File: rtl/router_muxn_rr.sv
// router_muxn_rr: round-robin N:1 packet multiplexer feeding the output port for destination PORTNO
module router_muxn_rr #(
  parameter int NPORTS = 4,
  parameter int PORTNO = 1,
  parameter int DW = 64,
  parameter int DESTW = 8
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NPORTS-1:0][DW-1:0]    D,
  input  logic [NPORTS-1:0][DESTW-1:0] DEST,
  input  logic [NPORTS-1:0]            DEST_VALID,
  input  logic [NPORTS-1:0]            D_HDR_VALID,
  input  logic [NPORTS-1:0]            D_PLD_VALID,
  input  logic [NPORTS-1:0]            D_SOF,
  input  logic [NPORTS-1:0]            D_EOF,
  input  logic                         Q_BP,
  output logic [NPORTS-1:0]            D_BP,
  output logic [DW-1:0]                Q,
  output logic                         Q_HDR_VALID,
  output logic                         Q_PLD_VALID,
  output logic                         Q_SOF,
  output logic                         Q_EOF,
  output logic [NPORTS-1:0]            GRANT,
  output logic                         COLLISION
);
  localparam int PW = $clog2(NPORTS);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, own_q, own_d, win, sel;
  logic [NPORTS-1:0] grant_q, grant_d, req, sel_oh;
  logic [DW-1:0] q_q, q_d;
  logic [3:0] flg_q, flg_d;
  logic col_q, col_d, found, lock, abort, accept;
  int idx;
  always_comb begin
    req = '0;
    for (int i = 0; i < NPORTS; i++) req[i] = DEST_VALID[i] && DEST[i] == DESTW'(PORTNO);
  end
  // Search starts just after the last winner so a loser is always ahead of it next time.
  always_comb begin
    win = ptr_q;
    found = 1'b0;
    idx = 0;
    for (int k = 1; k <= NPORTS; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NPORTS) idx = idx - NPORTS;
      if (!found && req[idx]) begin
        win = PW'(idx);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    lock = state_q == LOCK;
    sel = lock ? own_q : win;
    sel_oh = NPORTS'(1) << sel;
    abort = lock && !req[own_q];
    accept = !Q_BP && (lock ? req[own_q] : found);
    D_BP = RST ? '0 : req & ~(sel_oh & {NPORTS{accept}});
    state_d = state_q;
    ptr_d = ptr_q;
    own_d = own_q;
    grant_d = grant_q;
    q_d = accept ? D[sel] : q_q;
    flg_d = accept ? {D_SOF[sel], D_HDR_VALID[sel], D_PLD_VALID[sel], D_EOF[sel]} : (Q_BP && !abort) ? flg_q : 4'b0;
    col_d = !lock && accept && $countones(req) > 1;
    if (!lock) begin
      grant_d = accept ? sel_oh : '0;
      if (accept) begin
        ptr_d = win;
        own_d = win;
        state_d = D_EOF[win] ? IDLE : LOCK;
      end
    end else if (abort || (accept && D_EOF[own_q])) begin
      state_d = IDLE;
      grant_d = '0;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q <= PW'(NPORTS - 1);
      own_q <= '0;
      grant_q <= '0;
      q_q <= '0;
      flg_q <= '0;
      col_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      own_q <= own_d;
      grant_q <= grant_d;
      q_q <= q_d;
      flg_q <= flg_d;
      col_q <= col_d;
    end
  end
  assign GRANT = grant_q;
  assign Q = q_q;
  assign {Q_SOF, Q_HDR_VALID, Q_PLD_VALID, Q_EOF} = flg_q;
  assign COLLISION = col_q;
endmodule
